startup_seq_mon: RTL and testbench

- Parametrised startup sequencer and run-time temperature monitor for the mixed-signal IC.
- Receives a serial config word and applies opamp gain. Enables the ring oscillator, waits, then filters the temperature-sensor ADC to choose bias current and core clock rate.
- Releases the amp and core resets, raises o_ready, then keeps tracking temperature with hysteresis.
- Single clock domain: i_sclk/i_sdin are oversampled on i_clk. The core clock rate is delivered as an enable strobe, not a generated clock.

---
 rtl/startup_seq_mon.sv | 232 +++++++++++++++++++++++
 tb/tb_startup_seq_mon.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/startup_seq_mon.sv
// Startup sequencer and run-time temperature monitor.
// Receives a serial config frame, applies opamp gain, enables the ring
// oscillator, filters the temperature ADC to choose bias and core clock rate,
// releases resets, then keeps tracking temperature with hysteresis.
// Optional feature macro: STARTUP_SEQ_CFG_PARITY_EN (even parity bit appended
// to the config frame, sticky o_cfg_err on mismatch).
module startup_seq_mon #(
    parameter int unsigned ADC_W     = 4,
    parameter int unsigned GAIN_W    = 3,
    parameter int unsigned CFG_W     = 5,
    parameter int unsigned WAIT_CYC  = 5,
    parameter int unsigned FILT_LOG2 = 2,
    parameter int unsigned TH_HI     = 12,
    parameter int unsigned TH_LO     = 8,
    parameter int unsigned DIV       = 4
) (
    input  logic              i_clk,
    input  logic              i_resetbAll,
    input  logic              i_sclk,
    input  logic              i_sdin,
    input  logic [ADC_W-1:0]  i_ADCout,
    output logic              o_Ibias_2x,
    output logic              o_core_clk_en,
    output logic              o_ready,
    output logic              o_resetb_amp,
    output logic [GAIN_W-1:0] o_gain,
    output logic              o_enableRO,
    output logic              o_resetb_core,
    output logic              o_cfg_err
);

    localparam int unsigned N      = 1 << FILT_LOG2;
    localparam int unsigned SUM_W  = ADC_W + FILT_LOG2;
`ifdef STARTUP_SEQ_CFG_PARITY_EN
    localparam int unsigned FRAME_W = CFG_W + 1;
`else
    localparam int unsigned FRAME_W = CFG_W;
`endif
    localparam int unsigned BCNT_W = $clog2(FRAME_W + 1);
    localparam int unsigned WCNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int unsigned FILL_W = $clog2(N + 1);
    localparam int unsigned DCNT_W = $clog2(DIV);
    localparam logic [ADC_W-1:0] TH_HI_V = ADC_W'(TH_HI);
    localparam logic [ADC_W-1:0] TH_LO_V = ADC_W'(TH_LO);

    typedef enum logic [3:0] {
        StReset, StWaitSer, StSetGain, StEnRo, StWait1,
        StFilter, StSetRes, StWait2, StReady
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic                r_sdin_s1, r_sdin_s2;
    logic [FRAME_W-1:0]  r_cfg;
    logic [BCNT_W-1:0]   r_bit_cnt;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic [ADC_W-1:0]    r_dly [N];
    logic [SUM_W-1:0]    r_sum;
    logic [FILL_W-1:0]   r_fill_cnt;
    logic [ADC_W-1:0]    r_avg;
    logic                r_avg_valid;
    logic                r_mode_set, r_slow;
    logic                w_mode_set_nxt, w_slow_nxt, w_mode_chg;
    logic [DCNT_W-1:0]   r_div_cnt;
    logic [GAIN_W-1:0]   r_gain;
    logic                r_enable_ro, r_resetb_amp, r_resetb_core, r_ready;
    logic                w_sclk_rise, w_frame_done, w_par_ok, w_wait_done;
    logic                w_unused_cfg;

    assign w_sclk_rise  = r_sclk_s2 & ~r_sclk_s3;
    assign w_frame_done = (r_bit_cnt == BCNT_W'(FRAME_W));
    assign w_wait_done  = (r_wait_cnt == WCNT_W'(WAIT_CYC - 1));
`ifdef STARTUP_SEQ_CFG_PARITY_EN
    assign w_par_ok     = ((^r_cfg[CFG_W-1:0]) == r_cfg[CFG_W]);
`else
    assign w_par_ok     = 1'b1;
`endif
    // Upper config bits beyond the gain field are reserved.
    assign w_unused_cfg = ^r_cfg;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_resetbAll) r_state <= StReset;
        else              r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StReset:   w_state_nxt = StWaitSer;
            StWaitSer: if (w_frame_done && w_par_ok) w_state_nxt = StSetGain;
            StSetGain: w_state_nxt = StEnRo;
            StEnRo:    w_state_nxt = StWait1;
            StWait1:   if (w_wait_done) w_state_nxt = StFilter;
            StFilter:  if (r_avg_valid) w_state_nxt = StSetRes;
            StSetRes:  w_state_nxt = StWait2;
            StWait2:   if (w_wait_done) w_state_nxt = StReady;
            StReady:   w_state_nxt = StReady;
            default:   w_state_nxt = StReset;
        endcase
    end

    // Synchronisers and serial shift-in; bits enter at the MSB so the first
    // received bit lands in cfg[0] once the frame is complete.
    always_ff @(posedge i_clk) begin
        if (!i_resetbAll) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_sdin_s1 <= 1'b0;
            r_sdin_s2 <= 1'b0;
            r_cfg     <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_sclk_s1 <= i_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_sdin_s1 <= i_sdin;
            r_sdin_s2 <= r_sdin_s1;
            if (r_state == StWaitSer) begin
                if (w_frame_done) begin
                    r_bit_cnt <= '0;
                end else if (w_sclk_rise) begin
                    r_cfg     <= {r_sdin_s2, r_cfg[FRAME_W-1:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    // Dwell counter shared by both wait states.
    always_ff @(posedge i_clk) begin
        if (!i_resetbAll) begin
            r_wait_cnt <= '0;
        end else if ((r_state == StWait1) || (r_state == StWait2)) begin
            r_wait_cnt <= w_wait_done ? '0 : r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Moving-average filter; sum of N samples always fits in SUM_W bits.
    always_ff @(posedge i_clk) begin
        if (!i_resetbAll) begin
            for (int i = 0; i < int'(N); i++) r_dly[i] <= '0;
            r_sum       <= '0;
            r_fill_cnt  <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_dly[0] <= i_ADCout;
            for (int i = 1; i < int'(N); i++) r_dly[i] <= r_dly[i-1];
            r_sum <= r_sum + SUM_W'(i_ADCout) - SUM_W'(r_dly[N-1]);
            if (r_fill_cnt != FILL_W'(N)) r_fill_cnt <= r_fill_cnt + 1'b1;
            r_avg       <= ADC_W'(r_sum >> FILT_LOG2);
            r_avg_valid <= r_avg_valid | (r_fill_cnt == FILL_W'(N));
        end
    end

    // Mode selection: initial choice in FILTER, hysteresis tracking in READY.
    always_comb begin
        w_mode_set_nxt = r_mode_set;
        w_slow_nxt     = r_slow;
        if ((r_state == StFilter) && r_avg_valid) begin
            w_mode_set_nxt = 1'b1;
            w_slow_nxt     = (r_avg > TH_HI_V);
        end else if (r_state == StReady) begin
            if (r_avg > TH_HI_V)      w_slow_nxt = 1'b1;
            else if (r_avg < TH_LO_V) w_slow_nxt = 1'b0;
        end
        w_mode_chg = (w_slow_nxt != r_slow) | (w_mode_set_nxt & ~r_mode_set);
    end

    // Mode registers and core-enable divider, restarted on any mode change.
    always_ff @(posedge i_clk) begin
        if (!i_resetbAll) begin
            r_mode_set <= 1'b0;
            r_slow     <= 1'b0;
            r_div_cnt  <= '0;
        end else begin
            r_mode_set <= w_mode_set_nxt;
            r_slow     <= w_slow_nxt;
            if (w_mode_chg || (r_div_cnt == DCNT_W'(DIV - 1))) r_div_cnt <= '0;
            else                                               r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Sequenced outputs, each set on leaving its state and held afterwards.
    always_ff @(posedge i_clk) begin
        if (!i_resetbAll) begin
            r_gain        <= '0;
            r_enable_ro   <= 1'b0;
            r_resetb_amp  <= 1'b0;
            r_resetb_core <= 1'b0;
            r_ready       <= 1'b0;
        end else begin
            if (r_state == StSetGain) r_gain <= r_cfg[GAIN_W-1:0];
            if (r_state == StEnRo)    r_enable_ro <= 1'b1;
            if (r_state == StSetRes) begin
                r_resetb_amp  <= 1'b1;
                r_resetb_core <= 1'b1;
            end
            if (r_state == StReady)   r_ready <= 1'b1;
        end
    end

`ifdef STARTUP_SEQ_CFG_PARITY_EN
    logic r_cfg_err;

    // Sticky flag for a frame whose parity bit disagrees with its payload.
    always_ff @(posedge i_clk) begin
        if (!i_resetbAll) begin
            r_cfg_err <= 1'b0;
        end else if ((r_state == StWaitSer) && w_frame_done && !w_par_ok) begin
            r_cfg_err <= 1'b1;
        end
    end
    assign o_cfg_err = r_cfg_err;
`else
    assign o_cfg_err = 1'b0;
`endif

    assign o_gain        = r_gain;
    assign o_enableRO    = r_enable_ro;
    assign o_resetb_amp  = r_resetb_amp;
    assign o_resetb_core = r_resetb_core;
    assign o_ready       = r_ready;
    assign o_Ibias_2x    = r_mode_set & r_slow;
    assign o_core_clk_en = r_mode_set & (~r_slow | (r_div_cnt == DCNT_W'(DIV - 1)));

endmodule

// File: tb/tb_startup_seq_mon.sv
// Self-checking bench for startup_seq_mon with default parameters.
// Expected gains and modes are queued when stimulus is driven and popped when
// the DUT reaches the point where they must be visible.
module tb_startup_seq_mon;

    localparam int N        = 4;
    localparam int WAIT_CYC = 5;
    localparam int DIV      = 4;

    logic       i_clk = 1'b0;
    logic       i_resetbAll;
    logic       i_sclk;
    logic       i_sdin;
    logic [3:0] i_ADCout;
    logic       o_Ibias_2x, o_core_clk_en, o_ready, o_resetb_amp;
    logic [2:0] o_gain;
    logic       o_enableRO, o_resetb_core, o_cfg_err;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    startup_seq_mon dut (
        .i_clk         (i_clk),
        .i_resetbAll   (i_resetbAll),
        .i_sclk        (i_sclk),
        .i_sdin        (i_sdin),
        .i_ADCout      (i_ADCout),
        .o_Ibias_2x    (o_Ibias_2x),
        .o_core_clk_en (o_core_clk_en),
        .o_ready       (o_ready),
        .o_resetb_amp  (o_resetb_amp),
        .o_gain        (o_gain),
        .o_enableRO    (o_enableRO),
        .o_resetb_core (o_resetb_core),
        .o_cfg_err     (o_cfg_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [9:0] out_vec();
        return {o_Ibias_2x, o_core_clk_en, o_ready, o_resetb_amp, o_gain,
                o_enableRO, o_resetb_core, o_cfg_err};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // One serial bit at i_clk/4: data changes with the falling sclk.
    task automatic send_bit(input logic b);
        i_sclk = 1'b0;
        i_sdin = b;
        tick(2);
        i_sclk = 1'b1;
        tick(2);
    endtask

    task automatic send_cfg(input logic [4:0] cfg, input bit bad_par);
        for (int k = 0; k < 5; k++) send_bit(cfg[k]);
`ifdef STARTUP_SEQ_CFG_PARITY_EN
        send_bit((^cfg) ^ bad_par);
`else
        if (bad_par) $display("note: parity stimulus ignored in this build");
`endif
        i_sclk = 1'b0;
    endtask

    // Negedges until the selected condition holds; -1 when the budget expires.
    task automatic wait_sig(input int sel, input int budget, output int cyc);
        logic hit;
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge i_clk);
            case (sel)
                0:       hit = o_enableRO;
                1:       hit = o_resetb_amp;
                2:       hit = o_ready;
                default: hit = !o_Ibias_2x;
            endcase
            if (hit) begin
                cyc = c;
                return;
            end
        end
    endtask

    task automatic apply_reset();
        i_resetbAll = 1'b0;
        i_sclk      = 1'b0;
        i_sdin      = 1'b0;
        tick(3);
        i_resetbAll = 1'b1;
    endtask

    task automatic test_reset();
        i_ADCout = 4'd0;
        i_resetbAll = 1'b0;
        i_sclk = 1'b0;
        i_sdin = 1'b0;
        tick(3);
        n_cmp++;
        if (out_vec() !== 10'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", out_vec(), 10'd0);
        end
        i_resetbAll = 1'b1;
        tick(10);
        n_cmp++;
        if (out_vec() !== 10'd0) begin
            n_err++;
            $display("FAIL idle_no_frame: got %b want %b", out_vec(), 10'd0);
        end
    endtask

    task automatic test_startup_slow();
        int t_gain, t_ro, cyc, last, npulse;
        logic [2:0] exp_gain;
        i_ADCout = 4'd14;
        exp_q.push_back(3'b101);
        send_cfg(5'b01101, 1'b0);
        exp_gain = 3'(exp_q.pop_front());
        t_gain = -1;
        t_ro   = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge i_clk);
            if (t_gain < 0 && o_gain === exp_gain) t_gain = c;
            if (o_enableRO === 1'b1) begin
                t_ro = c;
                break;
            end
        end
        n_cmp++;
        if (t_ro < 0 || o_gain !== exp_gain) begin
            n_err++;
            $display("FAIL gain: got %b (ro at %0d) want %b", o_gain, t_ro, exp_gain);
        end
        n_cmp++;
        if (t_ro - t_gain != 1) begin
            n_err++;
            $display("FAIL gain_to_ro: got %0d cycles want 1", t_ro - t_gain);
        end
        n_cmp++;
        if (o_core_clk_en !== 1'b0 || o_Ibias_2x !== 1'b0) begin
            n_err++;
            $display("FAIL pre_filter_mode: got en=%b ib=%b want 0 0",
                     o_core_clk_en, o_Ibias_2x);
        end
        // Filter is already valid, so FILTER and SET_RES take one cycle each.
        wait_sig(1, 50, cyc);
        n_cmp++;
        if (cyc - 2 != WAIT_CYC) begin
            n_err++;
            $display("FAIL wait1_dwell: got %0d want %0d", cyc - 2, WAIT_CYC);
        end
        n_cmp++;
        if (o_Ibias_2x !== 1'b1 || o_resetb_core !== 1'b1 || o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL slow_at_res: got ib=%b rc=%b rdy=%b want 1 1 0",
                     o_Ibias_2x, o_resetb_core, o_ready);
        end
        wait_sig(2, 50, cyc);
        n_cmp++;
        if (cyc != WAIT_CYC + 1) begin
            n_err++;
            $display("FAIL res_to_ready: got %0d want %0d", cyc, WAIT_CYC + 1);
        end
        last = -1;
        npulse = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge i_clk);
            if (o_core_clk_en === 1'b1) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (c - last != DIV) begin
                        n_err++;
                        $display("FAIL slow_period: got %0d want %0d", c - last, DIV);
                    end
                end
                last = c;
                npulse++;
            end
        end
        n_cmp++;
        if (npulse != 16 / DIV) begin
            n_err++;
            $display("FAIL slow_pulses: got %0d want %0d", npulse, 16 / DIV);
        end
        n_cmp++;
        if (o_cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_err_clean: got %b want 0", o_cfg_err);
        end
    endtask

    task automatic test_sclk_ignored();
        for (int k = 0; k < 6; k++) send_bit(1'($urandom_range(0, 1)));
        i_sclk = 1'b0;
        tick(4);
        n_cmp++;
        if (o_gain !== 3'b101 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL sclk_in_ready: got gain=%b rdy=%b want 101 1", o_gain, o_ready);
        end
    endtask

    task automatic test_hysteresis();
        int cyc, bad;
        i_ADCout = 4'd10;
        exp_q.push_back(1);
        tick(12);
        n_cmp++;
        if (o_Ibias_2x !== 1'(exp_q.pop_front())) begin
            n_err++;
            $display("FAIL hyst_hold: got ib=%b want 1", o_Ibias_2x);
        end
        i_ADCout = 4'd6;
        exp_q.push_back(0);
        wait_sig(3, 20, cyc);
        n_cmp++;
        if (cyc < 1 || cyc > N + 2) begin
            n_err++;
            $display("FAIL fast_latency: got %0d want 1..%0d", cyc, N + 2);
        end
        n_cmp++;
        if (o_Ibias_2x !== 1'(exp_q.pop_front())) begin
            n_err++;
            $display("FAIL fast_bias: got ib=%b want 0", o_Ibias_2x);
        end
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_core_clk_en !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL fast_en_const: got %0d low cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [2:0] exp_gain;
        apply_reset();
        i_ADCout = 4'd6;
        exp_q.push_back(3'b010);
        send_cfg(5'b11010, 1'b0);
        wait_sig(0, 50, cyc);
        exp_gain = 3'(exp_q.pop_front());
        n_cmp++;
        if (cyc < 0 || o_gain !== exp_gain) begin
            n_err++;
            $display("FAIL gain2: got %b want %b", o_gain, exp_gain);
        end
        // sclk activity during WAIT1 must not disturb the applied gain.
        send_bit(1'b1);
        i_sclk = 1'b0;
        wait_sig(1, 50, cyc);
        n_cmp++;
        if (cyc < 0 || o_gain !== exp_gain || o_Ibias_2x !== 1'b0) begin
            n_err++;
            $display("FAIL wait1_sclk: got gain=%b ib=%b want %b 0", o_gain, o_Ibias_2x, exp_gain);
        end
        i_resetbAll = 1'b0;
        tick(1);
        n_cmp++;
        if (out_vec() !== 10'd0) begin
            n_err++;
            $display("FAIL reset_in_wait2: got %b want %b", out_vec(), 10'd0);
        end
        i_resetbAll = 1'b1;
        exp_q.push_back(3'b101);
        send_cfg(5'b01101, 1'b0);
        wait_sig(2, 200, cyc);
        exp_gain = 3'(exp_q.pop_front());
        n_cmp++;
        if (cyc < 0 || o_gain !== exp_gain || o_Ibias_2x !== 1'b0 || o_core_clk_en !== 1'b1) begin
            n_err++;
            $display("FAIL restart_fast: got rdy_cyc=%0d gain=%b ib=%b en=%b want >0 %b 0 1",
                     cyc, o_gain, o_Ibias_2x, o_core_clk_en, exp_gain);
        end
    endtask

`ifdef STARTUP_SEQ_CFG_PARITY_EN
    task automatic test_parity();
        int cyc;
        logic [2:0] exp_gain;
        apply_reset();
        i_ADCout = 4'd14;
        send_cfg(5'b01101, 1'b1);
        wait_sig(0, 20, cyc);
        n_cmp++;
        if (o_cfg_err !== 1'b1 || cyc != -1) begin
            n_err++;
            $display("FAIL parity_bad: got err=%b ro_cyc=%0d want 1 -1", o_cfg_err, cyc);
        end
        exp_q.push_back(3'b101);
        send_cfg(5'b01101, 1'b0);
        wait_sig(0, 50, cyc);
        exp_gain = 3'(exp_q.pop_front());
        n_cmp++;
        if (cyc < 0 || o_gain !== exp_gain || o_cfg_err !== 1'b1) begin
            n_err++;
            $display("FAIL parity_retry: got gain=%b err=%b want %b 1", o_gain, o_cfg_err, exp_gain);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_startup_slow();
        test_sclk_ignored();
        test_hysteresis();
        test_reset_mid();
`ifdef STARTUP_SEQ_CFG_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
